// File: rtl/simon_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : simon_tone_sequencer
// Purpose  : Plays a stored Simon colour sequence as timed notes and gaps on a
//            shared tone generator, and passes button tones through when idle.
//            Define SEQ_ABORT_EN to add the abort input.
// Revision : 1.0  initial release
// ============================================================================
module simon_tone_sequencer #(
   parameter int FREQ0   = 262,
   parameter int FREQ1   = 330,
   parameter int FREQ2   = 392,
   parameter int FREQ3   = 523,
   parameter int MAX_LEN = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [15:0]                        clk_counter,
   input  logic                               start,
   input  logic [$clog2(MAX_LEN+1)-1:0]       seq_len,
   input  logic [11:0]                        note_ms,
   input  logic [11:0]                        gap_ms,
   input  logic [3:0]                         btn_tone,
`ifdef SEQ_ABORT_EN
   input  logic                               abort,
`endif
   output logic [$clog2(MAX_LEN)-1:0]         rd_addr,
   input  logic [1:0]                         rd_data,
   output logic [9:0]                         frequency,
   output logic [3:0]                         led,
   output logic                               busy,
   output logic                               done
);

   localparam int c_ADDR_W = $clog2(MAX_LEN);
   localparam int c_LEN_W  = $clog2(MAX_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_NOTE  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_ADDR_W-1:0]   r_index;
   logic [c_LEN_W-1:0]    r_len;
   logic [11:0]           r_note;
   logic [11:0]           r_gap;
   logic [15:0]           r_presc;
   logic [11:0]           r_ms;
   logic [9:0]            r_freq;
   logic [3:0]            r_led;

   logic [15:0]           w_cc;
   logic [11:0]           w_dur;
   logic                  w_tick;
   logic                  w_expire;
   logic                  w_last;
   logic                  w_abort;
   logic                  w_enter_timed;
   logic [c_LEN_W-1:0]    w_len_clamped;
   logic                  w_btn_onehot;
   logic [9:0]            w_btn_freq;

   function automatic logic [9:0] f_colour_freq(input logic [1:0] colour);
      case (colour)
         2'd0:    return 10'(FREQ0);
         2'd1:    return 10'(FREQ1);
         2'd2:    return 10'(FREQ2);
         default: return 10'(FREQ3);
      endcase
   endfunction

`ifdef SEQ_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // A zero clocks-per-ms setting behaves as one cycle per millisecond.
   assign w_cc          = (clk_counter == 16'd0) ? 16'd1 : clk_counter;
   assign w_dur         = (r_state == S_NOTE) ? r_note : r_gap;
   assign w_tick        = (r_presc == w_cc - 16'd1);
   assign w_expire      = w_tick && (r_ms == w_dur - 12'd1);
   assign w_last        = (c_LEN_W'(r_index) + c_LEN_W'(1)) == r_len;
   assign w_len_clamped = (seq_len > c_LEN_W'(MAX_LEN)) ? c_LEN_W'(MAX_LEN) : seq_len;
   assign w_btn_onehot  = (btn_tone == 4'b0001) || (btn_tone == 4'b0010) ||
                          (btn_tone == 4'b0100) || (btn_tone == 4'b1000);
   assign w_enter_timed = (w_state_nxt != r_state) &&
                          ((w_state_nxt == S_NOTE) || (w_state_nxt == S_GAP));

   always_comb begin
      w_btn_freq = 10'd0;
      case (btn_tone)
         4'b0001: w_btn_freq = f_colour_freq(2'd0);
         4'b0010: w_btn_freq = f_colour_freq(2'd1);
         4'b0100: w_btn_freq = f_colour_freq(2'd2);
         4'b1000: w_btn_freq = f_colour_freq(2'd3);
         default: w_btn_freq = 10'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = (w_len_clamped == '0) ? S_DONE : S_FETCH;
         S_FETCH: w_state_nxt = S_WAIT;
         S_WAIT:  w_state_nxt = S_NOTE;
         S_NOTE:  if (w_expire) w_state_nxt = S_GAP;
         S_GAP:   if (w_expire) w_state_nxt = w_last ? S_DONE : S_FETCH;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort && (r_state inside {S_FETCH, S_WAIT, S_NOTE, S_GAP}))
         w_state_nxt = S_DONE;
      busy = r_state inside {S_FETCH, S_WAIT, S_NOTE, S_GAP};
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_index <= '0;
         r_len   <= '0;
         r_note  <= 12'd0;
         r_gap   <= 12'd0;
         r_presc <= 16'd0;
         r_ms    <= 12'd0;
         r_freq  <= 10'd0;
         r_led   <= 4'd0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_index <= '0;
            r_len   <= w_len_clamped;
            r_note  <= (note_ms == 12'd0) ? 12'd1 : note_ms;
            r_gap   <= (gap_ms == 12'd0) ? 12'd1 : gap_ms;
         end
         if (r_state == S_GAP && w_state_nxt == S_FETCH)
            r_index <= r_index + c_ADDR_W'(1);

         // Timers restart on every entry so each phase is exactly dur*cc cycles.
         if (w_enter_timed) begin
            r_presc <= 16'd0;
            r_ms    <= 12'd0;
         end else if (r_state == S_NOTE || r_state == S_GAP) begin
            if (w_tick) begin
               r_presc <= 16'd0;
               r_ms    <= r_ms + 12'd1;
            end else begin
               r_presc <= r_presc + 16'd1;
            end
         end

         case (w_state_nxt)
            S_NOTE: begin
               if (r_state == S_WAIT) begin
                  r_freq <= f_colour_freq(rd_data);
                  r_led  <= 4'b0001 << rd_data;
               end
            end
            S_IDLE: begin
               if (r_state == S_IDLE && w_btn_onehot) begin
                  r_freq <= w_btn_freq;
                  r_led  <= btn_tone;
               end else begin
                  r_freq <= 10'd0;
                  r_led  <= 4'd0;
               end
            end
            default: begin
               r_freq <= 10'd0;
               r_led  <= 4'd0;
            end
         endcase
      end
   end

   assign rd_addr   = r_index;
   assign frequency = r_freq;
   assign led       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_simon_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_tone_sequencer
// Purpose  : Directed and randomized checks of simon_tone_sequencer against a
//            cycle-timeline model built from note/gap durations.
// Revision : 1.0  initial release
// ============================================================================
module tb_simon_tone_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] clk_counter;
   logic        start;
   logic [5:0]  seq_len;
   logic [11:0] note_ms;
   logic [11:0] gap_ms;
   logic [3:0]  btn_tone;
   logic [4:0]  rd_addr;
   logic [1:0]  rd_data;
   logic [9:0]  frequency;
   logic [3:0]  led;
   logic        busy;
   logic        done;
`ifdef SEQ_ABORT_EN
   logic        abort;
`endif

   logic [1:0]  mem [32];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [9:0] f;
      logic [3:0] l;
      logic       b;
      logic       d;
      int         a;
   } exp_t;

   simon_tone_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .clk_counter (clk_counter),
      .start       (start),
      .seq_len     (seq_len),
      .note_ms     (note_ms),
      .gap_ms      (gap_ms),
      .btn_tone    (btn_tone),
`ifdef SEQ_ABORT_EN
      .abort       (abort),
`endif
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frequency   (frequency),
      .led         (led),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   function automatic int tone_of(input int colour);
      case (colour)
         0:       return 262;
         1:       return 330;
         2:       return 392;
         default: return 523;
      endcase
   endfunction

   function automatic int btn_model(input logic [3:0] b);
      if ($countones(b) != 1) return 0;
      for (int k = 0; k < 4; k++)
         if (b[k]) return tone_of(k);
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string where, input exp_t e);
      chk({where, "/freq"}, 32'(frequency), 32'(e.f));
      chk({where, "/led"},  32'(led),       32'(e.l));
      chk({where, "/busy"}, 32'(busy),      32'(e.b));
      chk({where, "/done"}, 32'(done),      32'(e.d));
      if (e.a >= 0) chk({where, "/rd_addr"}, 32'(rd_addr), 32'(e.a));
   endtask

   // Drives a start pulse and checks every following cycle against a timeline
   // derived from FETCH+WAIT+note+gap per entry; stop_after>0 cuts it short.
   task automatic run_play(input int cc_in, input int len_in, input int n_in,
                           input int g_in, input int stop_after, input bit noise);
      exp_t q[$];
      int cc, len, n, g, lim;
      cc  = (cc_in == 0) ? 1 : cc_in;
      len = (len_in > 32) ? 32 : len_in;
      n   = (n_in == 0) ? 1 : n_in;
      g   = (g_in == 0) ? 1 : g_in;
      for (int e = 0; e < len; e++) begin
         q.push_back('{10'd0, 4'd0, 1'b1, 1'b0, e});
         q.push_back('{10'd0, 4'd0, 1'b1, 1'b0, -1});
         for (int c = 0; c < cc * n; c++)
            q.push_back('{10'(tone_of(int'(mem[e]))), 4'(1 << mem[e]), 1'b1, 1'b0, -1});
         for (int c = 0; c < cc * g; c++)
            q.push_back('{10'd0, 4'd0, 1'b1, 1'b0, -1});
      end
      q.push_back('{10'd0, 4'd0, 1'b0, 1'b1, -1});
      q.push_back('{10'd0, 4'd0, 1'b0, 1'b0, -1});
      lim = (stop_after > 0 && stop_after < q.size()) ? stop_after : q.size();

      clk_counter = 16'(cc_in);
      seq_len     = 6'(len_in);
      note_ms     = 12'(n_in);
      gap_ms      = 12'(g_in);
      btn_tone    = 4'd0;
      start       = 1'b1;
      for (int i = 0; i < lim; i++) begin
         step();
         cmp($sformatf("play[%0d]", i), q[i]);
         start = 1'b0;
         if (noise && i < q.size() - 1) begin
            btn_tone = 4'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            seq_len  = 6'($urandom);
            note_ms  = 12'($urandom_range(0, 9));
            gap_ms   = 12'($urandom_range(0, 9));
         end
      end
      start    = 1'b0;
      btn_tone = 4'd0;
   endtask

   initial begin
      logic [3:0] b;
      rst = 1'b1; start = 1'b0; clk_counter = 16'd4; seq_len = 6'd0;
      note_ms = 12'd0; gap_ms = 12'd0; btn_tone = 4'd0;
`ifdef SEQ_ABORT_EN
      abort = 1'b0;
`endif
      for (int k = 0; k < 32; k++) mem[k] = 2'($urandom_range(0, 3));

      repeat (3) step();
      cmp("reset", '{10'd0, 4'd0, 1'b0, 1'b0, 0});
      rst = 1'b0;
      step();
      cmp("idle0", '{10'd0, 4'd0, 1'b0, 1'b0, 0});

      // Reference example: colours {2,0}, 4 clk/ms, 3 ms notes, 2 ms gaps.
      mem[0] = 2'd2; mem[1] = 2'd0;
      run_play(4, 2, 3, 2, 0, 1'b0);

      btn_tone = 4'b1000; step();
      chk("btn1000/freq", 32'(frequency), 32'd523);
      chk("btn1000/led",  32'(led),       32'b1000);
      btn_tone = 4'b0011; step();
      chk("btn0011/freq", 32'(frequency), 32'd0);
      chk("btn0011/led",  32'(led),       32'd0);
      for (int k = 0; k < 10; k++) begin
         b = 4'($urandom);
         btn_tone = b; step();
         chk($sformatf("btn_rand%0d/freq", k), 32'(frequency), 32'(btn_model(b)));
         chk($sformatf("btn_rand%0d/led", k),  32'(led), (btn_model(b) != 0) ? 32'(b) : 32'd0);
      end
      btn_tone = 4'd0; step();

      run_play(3, 0, 2, 2, 0, 1'b0);

      // Random sequences with stray buttons, restarts and parameter churn.
      for (int t = 0; t < 5; t++) begin
         for (int k = 0; k < 32; k++) mem[k] = 2'($urandom_range(0, 3));
         run_play($urandom_range(0, 5), $urandom_range(1, 5), $urandom_range(0, 3),
                  $urandom_range(0, 3), 0, 1'b1);
      end

      // Oversized length is clamped to the memory depth.
      for (int k = 0; k < 32; k++) mem[k] = 2'($urandom_range(0, 3));
      run_play(1, 40, 0, 0, 0, 1'b0);

      // Reset while in the gap after entry 1, then a clean replay.
      mem[0] = 2'd1; mem[1] = 2'd3;
      run_play(4, 2, 3, 2, 40, 1'b0);
      rst = 1'b1; step();
      cmp("rst_mid_gap", '{10'd0, 4'd0, 1'b0, 1'b0, 0});
      rst = 1'b0; step();
      cmp("after_rst", '{10'd0, 4'd0, 1'b0, 1'b0, 0});
      run_play(4, 2, 1, 1, 0, 1'b0);

`ifdef SEQ_ABORT_EN
      run_play(2, 3, 4, 1, 5, 1'b0);
      abort = 1'b1; step(); abort = 1'b0;
      cmp("abort", '{10'd0, 4'd0, 1'b0, 1'b1, -1});
      step();
      cmp("abort_idle", '{10'd0, 4'd0, 1'b0, 1'b0, -1});
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
